// File: rtl/wii_cam_i2c_sequencer_if.sv
// wii_cam_i2c_sequencer_if: command/response bundle between the camera sequencer and i2c_master.
interface wii_cam_i2c_sequencer_if;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [95:0] i2c_data;
    logic [4:0]  i2c_packets;
    logic        i2c_rw;
    logic        i2c_ready;
    logic [95:0] i2c_rdata;

    modport master (
        output i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw,
        input  i2c_ready, i2c_rdata
    );

    modport slave (
        input  i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw,
        output i2c_ready, i2c_rdata
    );
endinterface

// File: rtl/wii_cam_i2c_sequencer.sv
// wii_cam_i2c_sequencer: runs the IR camera init table once, then polls 12-byte frames forever.
module wii_cam_i2c_sequencer #(
    parameter logic [6:0] CAM_ADDR    = 7'h58,
    parameter int         STEP_DELAY  = 1000,
    parameter int         POLL_CYCLES = 100000,
    parameter int         TIMEOUT     = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    wii_cam_i2c_sequencer_if.master       bus,
    output logic [95:0]                   frame_data,
    output logic                          frame_valid,
    output logic                          init_done,
    output logic                          error
);
    localparam int DP = (STEP_DELAY > POLL_CYCLES) ? STEP_DELAY : POLL_CYCLES;
    localparam int MX = (DP > TIMEOUT) ? DP : TIMEOUT;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DELAY, S_HALT} state_t;
    typedef enum logic [1:0] {OP_INIT, OP_PTR, OP_READ} op_t;

    state_t        r_state, w_state;
    op_t           r_op, w_op;
    logic [2:0]    r_step, w_step;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [95:0]   r_data, w_data;
    logic [4:0]    r_packets, w_packets;
    logic          r_rw, w_rw;
    logic [95:0]   r_frame, w_frame;
    logic          r_valid, w_valid;
    logic          r_init_done, w_init_done;
    logic          r_error, w_error;
    logic          w_start;
    logic          w_timeout;
    logic [CW-1:0] w_limit;

    // {value, register}: register byte goes out first on the bus
    function automatic logic [15:0] init_word(input logic [2:0] s);
        case (s)
            3'd0:    return 16'h0130;
            3'd1:    return 16'h0830;
            3'd2:    return 16'h9006;
            3'd3:    return 16'hC008;
            3'd4:    return 16'h401A;
            default: return 16'h3333;
        endcase
    endfunction

    function automatic logic [95:0] op_data(input op_t op, input logic [2:0] s);
        return (op == OP_INIT) ? {80'd0, init_word(s)} : (op == OP_PTR) ? 96'h36 : 96'd0;
    endfunction

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    // the only delay after an init write happens while op is still INIT; the poll delay runs with op already PTR
    assign w_limit   = (r_op == OP_INIT) ? CW'(STEP_DELAY - 1) : CW'(POLL_CYCLES - 1);

    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_step      = r_step;
        w_cnt       = r_cnt;
        w_data      = r_data;
        w_packets   = r_packets;
        w_rw        = r_rw;
        w_frame     = r_frame;
        w_valid     = 1'b0;
        w_init_done = r_init_done;
        w_error     = r_error;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: w_state = (enable && bus.i2c_ready) ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                if (bus.i2c_ready) begin
                    w_start = 1'b1;
                    w_state = S_WAIT_BUSY;
                    w_cnt   = '0;
                end
            end
            S_WAIT_BUSY: begin
                w_cnt = r_cnt + CW'(1);
                if (!bus.i2c_ready) begin
                    w_state = S_WAIT_DONE;
                    w_cnt   = '0;
                end else if (w_timeout) begin
                    w_state = S_HALT;
                    w_error = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                w_cnt = r_cnt + CW'(1);
                if (bus.i2c_ready) begin
                    w_cnt   = '0;
                    w_state = enable ? S_ISSUE : S_IDLE;
                    if (r_op == OP_INIT) begin
                        if (r_step != 3'd5) begin
                            w_step  = r_step + 3'd1;
                            w_state = S_DELAY;
                        end else begin
                            w_init_done = 1'b1;
                            w_op        = OP_PTR;
                        end
                    end else if (r_op == OP_PTR) begin
                        w_op = OP_READ;
                    end else begin
                        w_frame = bus.i2c_rdata;
                        w_valid = 1'b1;
                        w_op    = OP_PTR;
                        w_state = S_DELAY;
                    end
                end else if (w_timeout) begin
                    w_state = S_HALT;
                    w_error = 1'b1;
                end
            end
            S_DELAY: begin
                w_cnt = r_cnt + CW'(1);
                if (r_cnt == w_limit) begin
                    w_state = enable ? S_ISSUE : S_IDLE;
                    w_cnt   = '0;
                end
            end
            default: ;
        endcase
        // command fields are loaded on entry to ISSUE so they are already valid in the start cycle
        if (w_state == S_ISSUE && r_state != S_ISSUE) begin
            w_data    = op_data(w_op, w_step);
            w_packets = (w_op == OP_READ) ? 5'd12 : (w_op == OP_PTR) ? 5'd1 : 5'd2;
            w_rw      = (w_op != OP_READ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_INIT;
            r_step      <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_packets   <= '0;
            r_rw        <= 1'b1;
            r_frame     <= '0;
            r_valid     <= 1'b0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_step      <= w_step;
            r_cnt       <= w_cnt;
            r_data      <= w_data;
            r_packets   <= w_packets;
            r_rw        <= w_rw;
            r_frame     <= w_frame;
            r_valid     <= w_valid;
            r_init_done <= w_init_done;
            r_error     <= w_error;
        end
    end

    assign bus.i2c_start   = w_start;
    assign bus.i2c_addr    = CAM_ADDR;
    assign bus.i2c_data    = r_data;
    assign bus.i2c_packets = r_packets;
    assign bus.i2c_rw      = r_rw;
    assign frame_data      = r_frame;
    assign frame_valid     = r_valid;
    assign init_done       = r_init_done;
    assign error           = r_error;
endmodule

// File: tb/tb_wii_cam_i2c_sequencer.sv
// tb_wii_cam_i2c_sequencer: scoreboard bench with a behavioural i2c_master and a transaction-level reference model.
module tb_wii_cam_i2c_sequencer;
    localparam int STEP_DELAY  = 10;
    localparam int POLL_CYCLES = 50;
    localparam int TIMEOUT     = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [95:0] frame_data;
    logic        frame_valid, init_done, error;

    wii_cam_i2c_sequencer_if bus();

    wii_cam_i2c_sequencer #(
        .CAM_ADDR(7'h58), .STEP_DELAY(STEP_DELAY), .POLL_CYCLES(POLL_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus.master),
        .frame_data(frame_data), .frame_valid(frame_valid), .init_done(init_done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] data;
        logic [4:0]  packets;
        logic        rw;
        logic        init;
        int          gap;
    } txn_t;

    txn_t        exp_q[$];
    logic [95:0] exp_f[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, rise_cyc = 0, n_starts = 0, n_frames = 0;
    logic m_ready = 1'b1, m_block = 1'b0, m_abort = 1'b1, m_pending = 1'b0, m_is_read = 1'b0;
    int m_cnt = 0, m_n = 0, m_stall_at = -1, m_reads = 0;
    logic [95:0] m_rdata = '0;
    logic [95:0] first_frame = 96'h0B0A09080706050403020100;
    logic [7:0] init_reg[6] = '{8'h30, 8'h30, 8'h06, 8'h08, 8'h1A, 8'h33};
    logic [7:0] init_val[6] = '{8'h01, 8'h08, 8'h90, 8'hC0, 8'h40, 8'h33};
    logic prev_start = 1'b0, prev_valid = 1'b0;

    assign bus.i2c_ready = m_ready && !m_block;
    assign bus.i2c_rdata = m_rdata;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: the camera sees the init table once, then PTR/READ pairs forever
    task automatic push_init(input int n, input int first_gap, input int skip_idx);
        for (int i = 0; i < n; i++) begin
            txn_t t;
            t.data    = 96'({init_val[i], init_reg[i]});
            t.packets = 5'd2;
            t.rw      = 1'b1;
            t.init    = 1'b1;
            t.gap     = (i == 0) ? first_gap : (i == skip_idx) ? -1 : STEP_DELAY + 1;
            exp_q.push_back(t);
        end
    endtask

    task automatic push_ptr(input int gap);
        txn_t t;
        t.data = 96'h36; t.packets = 5'd1; t.rw = 1'b1; t.init = 1'b0; t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic push_read(input int gap);
        txn_t t;
        t.data = '0; t.packets = 5'd12; t.rw = 1'b0; t.init = 1'b0; t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic wait_starts(input int n, input int lim);
        int k = 0;
        while (n_starts < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_starts", 96'(n_starts >= n), 96'(1));
    endtask

    task automatic wait_frames(input int n, input int lim);
        int k = 0;
        while (n_frames < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frames", 96'(n_frames >= n), 96'(1));
    endtask

    task automatic chk_reset_vals();
        chk("rst_start", 96'(bus.i2c_start), 96'(0));
        chk("rst_addr", 96'(bus.i2c_addr), 96'(7'h58));
        chk("rst_data", bus.i2c_data, 96'(0));
        chk("rst_packets", 96'(bus.i2c_packets), 96'(0));
        chk("rst_rw", 96'(bus.i2c_rw), 96'(1));
        chk("rst_frame", frame_data, 96'(0));
        chk("rst_valid", 96'(frame_valid), 96'(0));
        chk("rst_init_done", 96'(init_done), 96'(0));
        chk("rst_error", 96'(error), 96'(0));
    endtask

    task automatic reset_on();
        @(negedge clk);
        reset   = 1'b1;
        m_abort = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_off();
        reset   = 1'b0;
        m_abort = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.i2c_start) begin
            m_pending = 1'b1;
            m_is_read = !bus.i2c_rw;
        end
    end

    // i2c_master model: ready drops the cycle after start and rises 20 cycles later
    always @(posedge clk) begin
        #1;
        if (m_abort) begin
            m_ready   = 1'b1;
            m_pending = 1'b0;
            m_cnt     = 0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_ready   = 1'b0;
            m_n++;
            m_cnt = (m_n == m_stall_at) ? -1 : 20;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_ready  = 1'b1;
                rise_cyc = cyc;
                if (m_is_read) begin
                    m_rdata = (m_reads == 0) ? first_frame : {$urandom, $urandom, $urandom};
                    m_reads++;
                    exp_f.push_back(m_rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        txn_t e;
        if (bus.i2c_start) begin
            n_starts++;
            chk("start_needs_ready", 96'(bus.i2c_ready), 96'(1));
            chk("start_one_cycle", 96'(prev_start), 96'(0));
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_start: got start with data %h expected none", bus.i2c_data);
            end else begin
                e = exp_q.pop_front();
                chk("txn_data", bus.i2c_data, e.data);
                chk("txn_packets", 96'(bus.i2c_packets), 96'(e.packets));
                chk("txn_rw", 96'(bus.i2c_rw), 96'(e.rw));
                chk("txn_addr", 96'(bus.i2c_addr), 96'(7'h58));
                chk("txn_init_done", 96'(init_done), 96'(!e.init));
                if (e.gap >= 0) chk("txn_gap", 96'(cyc - rise_cyc), 96'(e.gap));
            end
        end
        prev_start = bus.i2c_start;
        if (frame_valid) begin
            n_frames++;
            chk("valid_one_cycle", 96'(prev_valid), 96'(0));
            if (exp_f.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: got %h expected none", frame_data);
            end else begin
                chk("frame_data", frame_data, exp_f.pop_front());
            end
        end
        prev_valid = frame_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        int b;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset_off();
        repeat (10) @(negedge clk);
        chk("idle_no_start", 96'(n_starts), 96'(0));

        // init table, then two frame polls
        push_init(6, -1, -1);
        push_ptr(1);
        push_read(1);
        push_ptr(POLL_CYCLES + 1);
        push_read(1);
        enable = 1'b1;
        wait_starts(10, 3000);
        wait_frames(2, 500);
        chk("init_done_set", 96'(init_done), 96'(1));
        // enable dropped during a READ: frame still lands, then no further starts
        push_ptr(POLL_CYCLES + 1);
        push_read(1);
        wait_starts(12, 500);
        enable = 1'b0;
        wait_frames(3, 500);
        repeat (POLL_CYCLES + 40) @(negedge clk);
        chk("disabled_no_start", 96'(n_starts), 96'(12));
        push_ptr(-1);
        push_read(1);
        enable = 1'b1;
        wait_starts(14, 500);
        wait_frames(4, 500);
        chk("exp_q_drained", 96'(exp_q.size()), 96'(0));

        // reset mid-init at step 3, then ready held low across an ISSUE
        enable = 1'b0;
        reset_on();
        chk_reset_vals();
        reset_off();
        b = n_starts;
        push_init(6, -1, -1);
        enable = 1'b1;
        wait_starts(b + 4, 1000);
        repeat (5) @(negedge clk);
        reset_on();
        chk_reset_vals();
        exp_q.delete();
        push_init(6, -1, 1);
        push_ptr(1);
        reset_off();
        wait_starts(b + 5, 50);
        repeat (23) @(negedge clk);
        m_block = 1'b1;
        repeat (40) @(negedge clk);
        chk("blocked_no_start", 96'(n_starts), 96'(b + 5));
        m_block = 1'b0;
        wait_starts(b + 6, 5);
        wait_starts(b + 11, 1000);
        chk("init_done_after_reset", 96'(init_done), 96'(1));

        // camera stalls on the 3rd init write: timeout, halt, no more starts
        enable = 1'b0;
        reset_on();
        exp_q.delete();
        exp_f.delete();
        chk_reset_vals();
        m_stall_at = m_n + 3;
        push_init(3, -1, -1);
        reset_off();
        b = n_starts;
        enable = 1'b1;
        wait_starts(b + 3, 1000);
        repeat (TIMEOUT - 10) @(negedge clk);
        chk("error_not_early", 96'(error), 96'(0));
        repeat (30) @(negedge clk);
        chk("error_on_timeout", 96'(error), 96'(1));
        chk("init_done_clear", 96'(init_done), 96'(0));
        repeat (100) @(negedge clk);
        chk("halt_no_start", 96'(n_starts), 96'(b + 3));
        chk("halt_data", bus.i2c_data, 96'h9006);
        chk("halt_packets", 96'(bus.i2c_packets), 96'(2));
        chk("halt_rw", 96'(bus.i2c_rw), 96'(1));
        chk("error_sticky", 96'(error), 96'(1));
        chk("exp_q_empty", 96'(exp_q.size()), 96'(0));
        chk("exp_f_empty", 96'(exp_f.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wii_cam_i2c_sequencer.md
Name: wii_cam_i2c_sequencer

Overview:
Sequences the shared i2c_master for the IR camera.
- After reset and `enable`, issues a fixed 6-step register-init write table to the camera.
- Then loops forever: write the read-pointer byte, read a 12-byte frame, publish it, wait the poll interval.
- Sits between i2c_master and the blob/tracking logic; it is the only driver of i2c_master's start/addr/data/packets/rw inputs.

Parameters:
CAM_ADDR, 7'h58, 7-bit I2C address of the camera.
STEP_DELAY, 1000, idle cycles after each init write completes.
POLL_CYCLES, 100000, idle cycles between end of one frame read and the next pointer write.
TIMEOUT, 65535, max cycles spent waiting in any one i2c wait state.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  level; while low the sequencer stays IDLE or finishes its current transaction, then idles.
i2c_ready  in  1  from i2c_master; high = idle / transaction complete.
i2c_rdata  in  96  bytes read by i2c_master; byte i = [i*8 +: 8], byte 0 received first.
i2c_start  out  1  one-cycle start pulse to i2c_master.
i2c_addr  out  7  I2C address; constant CAM_ADDR.
i2c_data  out  96  write bytes; byte i = [i*8 +: 8], byte 0 sent first; unused bytes 0.
i2c_packets  out  5  byte count for the transaction.
i2c_rw  out  1  1 = write, 0 = read.
frame_data  out  96  last complete frame, registered.
frame_valid  out  1  one-cycle pulse when frame_data updates.
init_done  out  1  sticky high once all init steps have completed.
error  out  1  sticky high on timeout; cleared only by reset.

Behaviour:
- Reset values: i2c_start=0, i2c_addr=CAM_ADDR, i2c_data=0, i2c_packets=0, i2c_rw=1, frame_data=0, frame_valid=0, init_done=0, error=0; state=IDLE; step=0.
- Init table (2-byte writes, byte0 = register, byte1 = value), steps 0..5:
  - 30 01
  - 30 08
  - 06 90
  - 08 C0
  - 1A 40
  - 33 33
- States:
  - IDLE: enable=1 and i2c_ready=1 -> ISSUE.
  - ISSUE: drive addr/data/packets/rw for the current op; assert i2c_start for exactly this one cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait for i2c_ready=0 -> WAIT_DONE.
  - WAIT_DONE: wait for i2c_ready=1 -> op-dependent next state.
  - Init op done: step<5 -> DELAY(STEP_DELAY), step++, then ISSUE; step=5 -> init_done=1, op=PTR, go to ISSUE next cycle.
  - PTR op (packets=1, rw=1, data byte0=8'h36) done -> ISSUE with op=READ.
  - READ op (packets=12, rw=0, data=0) done -> latch frame_data<=i2c_rdata and pulse frame_valid the same cycle, then DELAY(POLL_CYCLES), then op=PTR.
  - DELAY counter counts N cycles exactly; after the delay, enable=0 -> IDLE (op/step retained), else -> ISSUE.
- i2c_data/packets/rw are held stable from ISSUE through WAIT_DONE.
- i2c_start is never asserted unless i2c_ready=1 in that cycle; if ready is low in ISSUE, hold without pulsing.
- Timeout: the wait counter resets on entering WAIT_BUSY or WAIT_DONE. Reaching TIMEOUT sets error=1 and enters HALT.
- HALT: all outputs hold, no further starts; only reset exits.
- enable falling mid-transaction: the transaction completes; the frame is still published if it was a READ; then the block idles.
- enable rising again: resumes at the retained op. Init is never repeated without reset.
- Reset mid-operation: immediate return to reset values next cycle; init restarts at step 0.
- Delay counter width: clog2 of max(STEP_DELAY, POLL_CYCLES, TIMEOUT)+1; no wrap.

Test Plan:
- Reset, enable=1, behavioural i2c_master model (ready drops 1 cycle after start, rises 20 cycles later) -> exactly 6 start pulses with data[15:0] = 0130, 0830, 9006, C008, 401A, 3333 (byte0 low); packets=2, rw=1; STEP_DELAY gaps; init_done rises after the 6th completes.
- Continue: model returns rdata = 96'h0B0A..00 (byte i = i) -> PTR write (packets=1, data[7:0]=36) then READ (packets=12, rw=0); frame_valid pulses once, frame_data=rdata; next PTR start exactly POLL_CYCLES after.
- Model holds ready low forever after the 3rd start -> error=1 after TIMEOUT cycles; no further starts; init_done stays 0.
- Drop enable during a READ -> frame still published, then IDLE with no starts. Re-enable -> next start is PTR, not an init write.
- Assert reset for 1 cycle mid-init (step 3) -> all outputs return to reset values; the next start carries data 0130.
- Ready held low by the model when ISSUE is entered -> no start pulse until ready=1, then exactly one pulse.
